// File: rtl/sap1_datapath.sv
// SAP-1 datapath: shared 8-bit bus, PC, MAR, 16x8 RAM, IR, A/B, adder/subtractor
// and output register, all steered by the 12-bit control word from the controller.
module sap1_datapath #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [11:0]       CW,
  input  logic              HLT,
  input  logic              PROG_EN,
  input  logic              PROG_WE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [DATA_W-1:0] PROG_DATA,
  output logic [3:0]        OPC,
  output logic [DATA_W-1:0] BUS,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] OUT_VAL,
  output logic              OUT_VLD,
  output logic              CARRY,
  output logic              BUS_ERR
);

  logic ce, co, mi, ro, ii, io, ai, ao, su, eo, bi, oi;
  logic active;
  logic multi_drv;
  logic [2:0] drv_cnt;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] out_q;
  logic              vld_q;
  logic              carry_q;
  logic              err_q;

  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] bus_val;

  assign {ce, co, mi, ro, ii, io, ai, ao, su, eo, bi, oi} = CW;

  // Registers only move when the controller is running and we are not programming.
  assign active = !HLT && !PROG_EN;

  assign ram_rd = ram[mar_q];

  // Subtraction is A + ~B + 1, so the top bit reads as "no borrow" when SU is set.
  assign alu_sum = {1'b0, a_q} + {1'b0, (su ? ~b_q : b_q)} + {{DATA_W{1'b0}}, su};

  assign drv_cnt = {2'b00, co} + {2'b00, ro} + {2'b00, io} + {2'b00, ao} + {2'b00, eo};
  assign multi_drv = drv_cnt > 3'd1;

  // Bus mux with fixed priority CO > RO > IO > AO > EO; idle bus reads zero.
  always_comb begin
    bus_val = '0;
    if (co) begin
      bus_val = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    end else if (ro) begin
      bus_val = ram_rd;
    end else if (io) begin
      bus_val = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
    end else if (ao) begin
      bus_val = a_q;
    end else if (eo) begin
      bus_val = alu_sum[DATA_W-1:0];
    end
  end

  // Programming port is the only RAM writer; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (PROG_EN && PROG_WE) begin
      ram[PROG_ADDR] <= PROG_DATA;
    end
  end

  // All architectural registers; every load samples the pre-edge bus value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vld_q <= active && oi;
      if (active) begin
        if (ce) pc_q <= pc_q + 1'b1;
        if (mi) mar_q <= bus_val[ADDR_W-1:0];
        if (ii) ir_q <= bus_val;
        if (ai) a_q <= bus_val;
        if (bi) b_q <= bus_val;
        if (oi) out_q <= bus_val;
        if (eo && ai) carry_q <= alu_sum[DATA_W];
        if (multi_drv) err_q <= 1'b1;
      end
    end
  end

  assign OPC     = ir_q[DATA_W-1:DATA_W-4];
  assign BUS     = bus_val;
  assign PC      = pc_q;
  assign OUT_VAL = out_q;
  assign OUT_VLD = vld_q;
  assign CARRY   = carry_q;
  assign BUS_ERR = err_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Scoreboard bench for sap1_datapath: the driver pushes expected post-edge values,
// a monitor pops and compares them after each rising edge, and OUT_VLD pulses are
// matched against a separate queue of expected output-register values.
module tb_sap1_datapath;

  localparam logic [11:0] C_CE = 12'h800;
  localparam logic [11:0] C_CO = 12'h400;
  localparam logic [11:0] C_MI = 12'h200;
  localparam logic [11:0] C_RO = 12'h100;
  localparam logic [11:0] C_II = 12'h080;
  localparam logic [11:0] C_IO = 12'h040;
  localparam logic [11:0] C_AI = 12'h020;
  localparam logic [11:0] C_AO = 12'h010;
  localparam logic [11:0] C_SU = 12'h008;
  localparam logic [11:0] C_EO = 12'h004;
  localparam logic [11:0] C_BI = 12'h002;
  localparam logic [11:0] C_OI = 12'h001;

  localparam int S_OPC    = 0;
  localparam int S_BUS    = 1;
  localparam int S_PC     = 2;
  localparam int S_OUTVAL = 3;
  localparam int S_OUTVLD = 4;
  localparam int S_CARRY  = 5;
  localparam int S_ERR    = 6;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } chk_t;

  logic        CLK;
  logic        RST;
  logic [11:0] CW;
  logic        HLT;
  logic        PROG_EN;
  logic        PROG_WE;
  logic [3:0]  PROG_ADDR;
  logic [7:0]  PROG_DATA;
  logic [3:0]  OPC;
  logic [7:0]  BUS;
  logic [3:0]  PC;
  logic [7:0]  OUT_VAL;
  logic        OUT_VLD;
  logic        CARRY;
  logic        BUS_ERR;

  chk_t       sb[$];
  logic [7:0] vld_q[$];
  int         total;
  int         bad;

  sap1_datapath dut (
    .CLK       (CLK),
    .RST       (RST),
    .CW        (CW),
    .HLT       (HLT),
    .PROG_EN   (PROG_EN),
    .PROG_WE   (PROG_WE),
    .PROG_ADDR (PROG_ADDR),
    .PROG_DATA (PROG_DATA),
    .OPC       (OPC),
    .BUS       (BUS),
    .PC        (PC),
    .OUT_VAL   (OUT_VAL),
    .OUT_VLD   (OUT_VLD),
    .CARRY     (CARRY),
    .BUS_ERR   (BUS_ERR)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [7:0] actual(input int sel);
    case (sel)
      S_OPC:    return {4'h0, OPC};
      S_BUS:    return BUS;
      S_PC:     return {4'h0, PC};
      S_OUTVAL: return OUT_VAL;
      S_OUTVLD: return {7'h00, OUT_VLD};
      S_CARRY:  return {7'h00, CARRY};
      default:  return {7'h00, BUS_ERR};
    endcase
  endfunction

  task automatic expectOut(input string name, input int sel, input logic [7:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic checkOutput(input chk_t c);
    logic [7:0] act;
    act = actual(c.sel);
    total++;
    if (act !== c.exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
    end
  endtask

  // Inputs change on the falling edge, like the real controller.
  task automatic applyStimulus(input logic [11:0] cw, input logic hlt, input logic pe,
                               input logic we, input logic [3:0] pa, input logic [7:0] pd);
    @(negedge CLK);
    CW        = cw;
    HLT       = hlt;
    PROG_EN   = pe;
    PROG_WE   = we;
    PROG_ADDR = pa;
    PROG_DATA = pd;
    if (!hlt && !pe && cw[0]) vld_q.push_back(8'h00);
  endtask

  task automatic step(input logic [11:0] cw);
    applyStimulus(cw, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    applyStimulus(12'h000, 1'b0, 1'b1, 1'b1, a, d);
  endtask

  // Record what OUT_VAL must be when the pulse from the last OI step appears.
  task automatic setOutExp(input logic [7:0] v);
    if (vld_q.size() > 0) vld_q[vld_q.size()-1] = v;
  endtask

  // Monitor: after every rising edge, drain the scoreboard and match output pulses.
  initial begin
    chk_t       c;
    logic [7:0] e;
    forever begin
      @(posedge CLK);
      #2;
      while (sb.size() > 0) begin
        c = sb.pop_front();
        checkOutput(c);
      end
      if (OUT_VLD === 1'b1) begin
        total++;
        if (vld_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL out_pulse: got unexpected pulse val %h expected none", OUT_VAL);
        end else begin
          e = vld_q.pop_front();
          if (OUT_VAL !== e) begin
            bad++;
            $display("[TB] FAIL out_pulse_val: got %h expected %h", OUT_VAL, e);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    total = 0;
    bad   = 0;
    RST       = 1'b1;
    CW        = 12'($urandom);
    HLT       = 1'b0;
    PROG_EN   = 1'b0;
    PROG_WE   = 1'b0;
    PROG_ADDR = 4'h0;
    PROG_DATA = 8'h00;
    expectOut("rst_pc", S_PC, 8'h00);
    expectOut("rst_opc", S_OPC, 8'h00);
    expectOut("rst_outval", S_OUTVAL, 8'h00);
    expectOut("rst_outvld", S_OUTVLD, 8'h00);
    expectOut("rst_carry", S_CARRY, 8'h00);
    expectOut("rst_buserr", S_ERR, 8'h00);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    expectOut("rst_bus_idle", S_BUS, 8'h00);
    @(negedge CLK);
    RST = 1'b0;

    prog(4'h0, 8'h1E);
    prog(4'h1, 8'h0F);
    prog(4'h2, 8'h05);
    prog(4'h3, 8'h07);
    prog(4'h4, 8'hFF);
    prog(4'h5, 8'h01);
    prog(4'hE, 8'd28);
    prog(4'hF, 8'd14);
    expectOut("prog_pc_hold", S_PC, 8'h00);
    expectOut("prog_vld_low", S_OUTVLD, 8'h00);

    step(C_CO | C_MI);
    expectOut("fetch_bus_pc", S_BUS, 8'h00);
    step(C_CE);
    expectOut("fetch_pc1", S_PC, 8'h01);
    step(C_RO | C_II);
    expectOut("fetch_opc", S_OPC, 8'h01);
    expectOut("fetch_ram0", S_BUS, 8'h1E);
    expectOut("fetch_pc_hold", S_PC, 8'h01);

    step(C_CO | C_MI | C_CE);
    expectOut("ptr_pc2", S_PC, 8'h02);
    step(C_RO | C_MI);
    expectOut("ptr_mar15", S_BUS, 8'd14);
    step(C_RO | C_BI);
    step(C_IO | C_MI);
    expectOut("io_bus", S_BUS, 8'h0E);
    step(C_RO | C_AI);
    expectOut("ld_a28", S_BUS, 8'd28);
    step(C_EO | C_AI);
    expectOut("add_bus_next", S_BUS, 8'd56);
    expectOut("add_carry", S_CARRY, 8'h00);
    step(C_OI | C_AO);
    setOutExp(8'd42);
    expectOut("add_a42", S_BUS, 8'd42);
    expectOut("add_outval", S_OUTVAL, 8'd42);
    step(C_OI | C_AO);
    setOutExp(8'd42);
    expectOut("b2b_vld", S_OUTVLD, 8'h01);
    step(12'h000);
    expectOut("vld_drop", S_OUTVLD, 8'h00);

    step(C_CO | C_MI | C_CE);
    step(C_RO | C_AI);
    step(C_CO | C_MI | C_CE);
    step(C_RO | C_BI);
    expectOut("ld_b07", S_BUS, 8'h07);
    step(C_SU | C_EO | C_AI);
    expectOut("sub_bus_next", S_BUS, 8'hF7);
    expectOut("sub_carry", S_CARRY, 8'h00);
    step(C_AO);
    expectOut("sub_a_fe", S_BUS, 8'hFE);
    step(C_CO | C_MI | C_CE);
    step(C_RO | C_AI);
    step(C_CO | C_MI | C_CE);
    step(C_RO | C_BI);
    step(C_EO | C_AI);
    expectOut("wrap_carry", S_CARRY, 8'h01);
    expectOut("wrap_bus_next", S_BUS, 8'h01);
    step(C_AO | C_AI);
    expectOut("wrap_a00", S_BUS, 8'h00);

    step(12'h000);
    #1 RST = 1'b1;
    #1 RST = 1'b0;
    expectOut("async_pc", S_PC, 8'h00);
    expectOut("async_opc", S_OPC, 8'h00);
    expectOut("async_outval", S_OUTVAL, 8'h00);
    expectOut("async_carry", S_CARRY, 8'h00);
    step(C_RO);
    expectOut("ram_persist", S_BUS, 8'h1E);

    for (int i = 0; i < 16; i++) begin
      step(C_CE);
      if (i == 14) expectOut("pc_15", S_PC, 8'h0F);
      if (i == 15) expectOut("pc_wrap", S_PC, 8'h00);
    end

    prog(4'h0, 8'h55);
    step(C_RO | C_AI);
    expectOut("reprog_read", S_BUS, 8'h55);
    step(C_CE);
    step(C_CE);
    step(C_CE);
    expectOut("pc_3", S_PC, 8'h03);
    step(C_OI | C_AO);
    setOutExp(8'h55);
    applyStimulus(C_CE | C_AI | C_OI, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    expectOut("halt_pc", S_PC, 8'h03);
    expectOut("halt_outval", S_OUTVAL, 8'h55);
    expectOut("halt_vld", S_OUTVLD, 8'h00);
    expectOut("halt_bus", S_BUS, 8'h00);
    step(C_AO);
    expectOut("halt_a_hold", S_BUS, 8'h55);
    expectOut("err_clear", S_ERR, 8'h00);

    step(C_CO | C_AO);
    expectOut("contend_bus", S_BUS, 8'h03);
    expectOut("contend_err", S_ERR, 8'h01);
    step(12'h000);
    expectOut("err_sticky", S_ERR, 8'h01);
    step(12'h000);
    #1 RST = 1'b1;
    #1 RST = 1'b0;
    expectOut("err_rst", S_ERR, 8'h00);

    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (sb.size() != 0 || vld_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftovers: got checks=%0d pulses=%0d expected 0", sb.size(), vld_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
